// File: rtl/pwm_timer.sv
// pwm_timer
// ---------------------------------------------------------------------------
// Register-write consumer for the SPI command decoder. It holds an 8-bit
// prescale divider (addr 0) and a CNT_W-bit compare value (addr 1), and
// produces a PWM waveform from a free-running period counter.
//
// The write bus is a level-held bus from another clock domain. It is
// synchronised into i_clk here, and each new write is turned into exactly
// one internal commit.
//
// Ports:
//   i_clk         system clock
//   i_rst_n       asynchronous reset, active HIGH (legacy name)
//   i_data[15:0]  write data, held stable between writes
//   i_addr        0 = divider, 1 = compare
//   i_we          write-valid level (not a pulse)
//   o_pwm         registered PWM output, high while count < o_cmp
//   o_period_end  one-cycle pulse on the cycle after the counter wraps
//   o_div[7:0]    current divider value
//   o_cmp         active compare value (loaded from the shadow at wrap)
//
// Write-bus semantics: there is no ready, and there is no pulse. A write is
// the bus contents {addr, data} held with i_we=1. A commit fires once the
// synchronised contents have been stable for two consecutive cycles and differ
// from the last committed snapshot. A commit also fires if i_we has been low
// since the last commit. The commit then disarms until one of those two
// conditions occurs again.
// ---------------------------------------------------------------------------
module pwm_timer #(
    parameter int                CNT_W       = 16,
    parameter logic [CNT_W-1:0]  PERIOD_MAX  = 16'hFFFF,
    parameter int                SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [15:0]      i_data,
    input  logic             i_addr,
    input  logic             i_we,
    output logic             o_pwm,
    output logic             o_period_end,
    output logic [7:0]       o_div,
    output logic [CNT_W-1:0] o_cmp
);

    localparam int SNAP_W = 17;          // {addr, data}
    localparam int BUS_W  = SNAP_W + 1;  // {we, addr, data}

    // Synchroniser chain and write-detection state
    logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q;
    logic [SNAP_W-1:0]                 snap_d_q;
    logic [SNAP_W-1:0]                 last_q, last_d;
    logic                              armed_q, armed_d;

    // Timer state
    logic [7:0]       div_q, div_d;
    logic [7:0]       presc_q, presc_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pe_q, pe_d;
    logic             pwm_q, pwm_d;

    // Synchronised view of the bus
    logic              we_s;
    logic [SNAP_W-1:0] snap_s;
    logic              commit;
    logic              commit_div;
    logic              commit_cmp;
    logic              tick;
    logic              wrap;

    assign we_s   = sync_q[SYNC_STAGES-1][BUS_W-1];
    assign snap_s = sync_q[SYNC_STAGES-1][SNAP_W-1:0];

    // Stable for two cycles guards against sampling a bus that is mid-change,
    // since the synchroniser flops of individual bits may resolve on
    // different cycles.
    assign commit     = armed_q & we_s & (snap_s == snap_d_q);
    assign commit_div = commit & ~snap_s[SNAP_W-1];
    assign commit_cmp = commit &  snap_s[SNAP_W-1];

    assign tick = (presc_q == div_q);
    assign wrap = tick & (cnt_q == PERIOD_MAX);

    always_comb begin
        last_d   = last_q;
        armed_d  = armed_q;
        div_d    = div_q;
        presc_d  = presc_q;
        shadow_d = shadow_q;
        cmp_d    = cmp_q;
        cnt_d    = cnt_q;
        pe_d     = 1'b0;
        pwm_d    = (cnt_q < cmp_q);

        // Write detection. The commit has priority over re-arming, so
        // that one stable snapshot yields only one commit.
        if (commit) begin
            armed_d = 1'b0;
            last_d  = snap_s;
        end else if (!we_s || (snap_s != last_q)) begin
            armed_d = 1'b1;
        end

        // Prescaler. A divider commit restarts it even on a tick cycle.
        if (commit_div) begin
            div_d   = snap_s[7:0];
            presc_d = 8'd0;
        end else if (tick) begin
            presc_d = 8'd0;
        end else begin
            presc_d = presc_q + 8'd1;
        end

        if (commit_cmp) begin
            shadow_d = snap_s[CNT_W-1:0];
        end

        // Period counter. On a wrap, the active compare loads the shadow
        // value from before this edge. A compare commit on the same edge
        // therefore takes effect at the next wrap.
        if (tick) begin
            if (wrap) begin
                cnt_d = '0;
                cmp_d = shadow_q;
                pe_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
            sync_q   <= '0;
            snap_d_q <= '0;
            last_q   <= '0;
            armed_q  <= 1'b1;
            div_q    <= '0;
            presc_q  <= '0;
            shadow_q <= '0;
            cmp_q    <= '0;
            cnt_q    <= '0;
            pe_q     <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            sync_q[0] <= {i_we, i_addr, i_data};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            snap_d_q <= snap_s;
            last_q   <= last_d;
            armed_q  <= armed_d;
            div_q    <= div_d;
            presc_q  <= presc_d;
            shadow_q <= shadow_d;
            cmp_q    <= cmp_d;
            cnt_q    <= cnt_d;
            pe_q     <= pe_d;
            pwm_q    <= pwm_d;
        end
    end

    assign o_pwm        = pwm_q;
    assign o_period_end = pe_q;
    assign o_div        = div_q;
    assign o_cmp        = cmp_q;

endmodule

// File: tb/tb_pwm_timer.sv
// Testbench for pwm_timer, with PERIOD_MAX reduced to 15.
// Each period-end pulse is one DUT "output event". At each pulse the monitor
// measures the following values and compares them with the next queued
// record:
//   - the length of the period that just ended
//   - the number of o_pwm-high cycles in it
//   - o_cmp and o_div
module tb_pwm_timer;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] PM = 16'd15;
  localparam int W = 56;  // {len[15:0], hi[15:0], cmp[15:0], div[7:0]}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic [15:0] i_data;
  logic i_addr;
  logic i_we;
  logic o_pwm;
  logic o_period_end;
  logic [7:0] o_div;
  logic [CNT_W-1:0] o_cmp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pwm_timer #(.CNT_W(CNT_W), .PERIOD_MAX(PM), .SYNC_STAGES(2)) dut (
    .i_clk(clk),
    .i_rst_n(rst),
    .i_data(i_data),
    .i_addr(i_addr),
    .i_we(i_we),
    .o_pwm(o_pwm),
    .o_period_end(o_period_end),
    .o_div(o_div),
    .o_cmp(o_cmp)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] len, input logic [15:0] hi,
                          input logic [15:0] cmp, input logic [7:0] dv);
    exp_q.push_back({len, hi, cmp, dv});
  endtask

  // Monitor: measures each period and compares it at the closing pulse.
  int since = 0;
  int hi_cnt = 0;
  always @(negedge clk) begin
    logic [W-1:0] exp;
    logic [W-1:0] got;
    if (rst) begin
      since = 0;
      hi_cnt = 0;
    end else begin
      since++;
      if (o_pwm) hi_cnt++;
      if (o_period_end) begin
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          got = {since[15:0], hi_cnt[15:0], o_cmp, o_div};
          compared++;
          if (got !== exp) begin
            mismatched++;
            $display("FAIL period_rec: got len=%0d hi=%0d cmp=%0h div=%0h, required len=%0d hi=%0d cmp=%0h div=%0h (t=%0t)",
                     got[55:40], got[39:24], got[23:8], got[7:0],
                     exp[55:40], exp[39:24], exp[23:8], exp[7:0], $time);
          end
        end
        since = 0;
        hi_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic a, input logic [15:0] d, input logic w);
    i_addr = a;
    i_data = d;
    i_we = w;
  endtask

  task automatic write(input logic a, input logic [15:0] d);
    @(posedge clk); #1;
    drive(a, d, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    i_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Returns at the negedge where o_period_end is seen (bounded).
  task automatic wait_pe();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_period_end && n < 400);
    if (!o_period_end) begin
      compared++;
      mismatched++;
      $display("FAIL wait_pe: no period_end within %0d cycles, required a pulse", n);
    end
  endtask

  // Aligns to one cycle after a wrap edge (posedge + 1).
  task automatic sync_pe();
    wait_pe();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [15:0] b_cmp [3] = '{16'd0, 16'd16, 16'd15};
  logic [15:0] b_prev[3] = '{16'd16, 16'd0, 16'd16};
  logic [15:0] b_hi  [3] = '{16'd0, 16'd16, 16'd15};

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", {31'd0, o_pwm}, 32'd0);
    check("rst_pe", {31'd0, o_period_end}, 32'd0);
    check("rst_div", {24'd0, o_div}, 32'd0);
    check("rst_cmp", {16'd0, o_cmp}, 32'd0);
    rst = 1'b0;

    // Set up div=5, cmp=8, then reset asynchronously while o_pwm is high.
    write(1'b0, 16'd5);
    write(1'b1, 16'd8);
    sync_pe();
    sync_pe();
    check("pre_div5", {24'd0, o_div}, 32'd5);
    check("pre_cmp8", {16'd0, o_cmp}, 32'd8);
    repeat (10) @(posedge clk);
    #1;
    check("pre_pwm_hi", {31'd0, o_pwm}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pwm", {31'd0, o_pwm}, 32'd0);
    check("midrst_pe", {31'd0, o_period_end}, 32'd0);
    check("midrst_div", {24'd0, o_div}, 32'd0);
    check("midrst_cmp", {16'd0, o_cmp}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset: period 16 and o_pwm constant low.
    sync_pe();
    push_exp(16'd16, 16'd0, 16'd0, 8'd0);
    push_exp(16'd16, 16'd0, 16'd0, 8'd0);
    wait_pe();
    wait_pe();

    // Divider write 16'hAB03: the upper byte is ignored, and o_div arrives
    // within 4 edges.
    @(posedge clk); #1;
    drive(1'b0, 16'hAB03, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("div_latency", {24'd0, o_div}, 32'h03);
    i_we = 1'b0;
    sync_pe();
    push_exp(16'd64, 16'd0, 16'd0, 8'd3);
    wait_pe();

    // Compare write goes through the shadow register.
    write(1'b0, 16'd0);
    sync_pe();
    push_exp(16'd16, 16'd0, 16'd4, 8'd0);
    push_exp(16'd16, 16'd4, 16'd4, 8'd0);
    push_exp(16'd16, 16'd4, 16'd4, 8'd0);
    drive(1'b1, 16'd4, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("shadow_hold", {16'd0, o_cmp}, 32'd0);
    i_we = 1'b0;
    wait_pe();
    wait_pe();
    wait_pe();

    // Back-to-back divider writes with i_we held, then a 1-clock glitch.
    @(posedge clk); #1;
    drive(1'b0, 16'd2, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("b2b_div2", {24'd0, o_div}, 32'd2);
    drive(1'b0, 16'd7, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("b2b_div7", {24'd0, o_div}, 32'd7);
    drive(1'b0, 16'd9, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 16'd7, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("glitch_div", {24'd0, o_div}, 32'd7);
    end
    sync_pe();
    push_exp(16'd128, 16'd32, 16'd4, 8'd7);
    wait_pe();
    i_we = 1'b0;
    write(1'b0, 16'd0);

    // Decoder-style sequence: idle bus with stale data, then a compare write.
    sync_pe();
    push_exp(16'd16, 16'd4, 16'h1234, 8'd0);
    push_exp(16'd16, 16'd16, 16'h1234, 8'd0);
    drive(1'b0, 16'h0012, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 16'h1234, 1'b1);
    wait_pe();
    wait_pe();
    i_we = 1'b0;

    // Compare boundaries: 0 (constant low), 16 (constant high), 15.
    for (int k = 0; k < 3; k++) begin
      sync_pe();
      push_exp(16'd16, b_prev[k], b_cmp[k], 8'd0);
      push_exp(16'd16, b_hi[k], b_cmp[k], 8'd0);
      drive(1'b1, b_cmp[k], 1'b1);
      repeat (6) @(posedge clk);
      #1;
      i_we = 1'b0;
      wait_pe();
      wait_pe();
    end

    // Compare commit lands exactly on the wrap edge. o_cmp takes the old
    // shadow value (15), and 6 follows one period later.
    sync_pe();
    push_exp(16'd16, 16'd15, 16'd15, 8'd0);
    push_exp(16'd16, 16'd15, 16'd6, 8'd0);
    push_exp(16'd16, 16'd6, 16'd6, 8'd0);
    repeat (11) @(posedge clk);
    #1;
    drive(1'b1, 16'd6, 1'b1);
    wait_pe();
    wait_pe();
    wait_pe();
    i_we = 1'b0;

    // Divider commit on a tick cycle (div=0): the counter must still advance.
    sync_pe();
    push_exp(16'd16, 16'd6, 16'd6, 8'd0);
    drive(1'b0, 16'd0, 1'b1);
    wait_pe();
    i_we = 1'b0;

    @(posedge clk); #1;
    check("exp_q_drained", exp_q.size(), 32'd0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
